// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command bytes and default timing for the host transmit
// and keyboard receive paths.
package ps2_pkg;

  // Host transmitter state machine encoding
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    TX,
    WAIT_ACK,
    DONE,
    ERROR
  } ps2_state_t;

  // Keyboard command / response bytes
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Default timing at 50 MHz: 120 us inhibit, 15 ms inter-edge timeout
  localparam int PS2_INHIBIT_CYCLES = 6000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;
  localparam int PS2_SYNC_STAGES    = 2;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-line synchroniser for raw PS2_CLK / PS2_DAT with a falling-edge
// detector on the clock line. Shared by the host transmit and keyboard
// receive paths.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] dat_pipe;
  logic                   clk_prev;

  // Shift raw levels through the synchroniser chain; idle bus level is high,
  // so reset to 1 to avoid a phantom edge coming out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_pipe <= '1;
      dat_pipe <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_pipe <= (clk_pipe << 1) | SYNC_STAGES'(clk_in);
      dat_pipe <= (dat_pipe << 1) | SYNC_STAGES'(dat_in);
      clk_prev <= clk_pipe[SYNC_STAGES-1];
    end
  end

  assign clk_sync = clk_pipe[SYNC_STAGES-1];
  assign dat_sync = dat_pipe[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then
// shifts one command byte out on device-generated clock edges and checks the
// device's acknowledge. Both lines are open-drain drive-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = PS2_SYNC_STAGES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       clk_drive_low,
  output logic       dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t       state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             dat_low_q, dat_low_d;

  logic             dat_sync;
  logic             fall;
  logic             unused_clk_sync;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (unused_clk_sync),
    .dat_sync (dat_sync),
    .fall     (fall)
  );

  // State, shift register, counters and the registered data drive
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dat_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      edge_cnt_q <= edge_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dat_low_q  <= dat_low_d;
    end
  end

  // Next-state and Moore outputs; device edges only count in TX / WAIT_ACK
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    edge_cnt_d    = edge_cnt_q;
    inh_cnt_d     = inh_cnt_q;
    to_cnt_d      = to_cnt_q;
    dat_low_d     = dat_low_q;
    clk_drive_low = 1'b0;
    dat_drive_low = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    error         = 1'b0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        dat_low_d = 1'b0;
        if (send) begin
          state_d    = INHIBIT;
          shreg_d    = ps2_frame(cmd_byte);
          edge_cnt_d = '0;
          inh_cnt_d  = '0;
        end
      end

      INHIBIT: begin
        clk_drive_low = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = START;
        else                                         inh_cnt_d = inh_cnt_q + INH_W'(1);
      end

      START: begin
        // Data low while clock is still held: the start bit. Clock is
        // released next cycle and the device starts clocking.
        clk_drive_low = 1'b1;
        dat_drive_low = 1'b1;
        dat_low_d     = 1'b1;
        to_cnt_d      = '0;
        state_d       = TX;
      end

      TX: begin
        dat_drive_low = dat_low_q;
        if (fall) begin
          // Edges 1..10 present D0..D7, parity, stop (stop releases the line)
          to_cnt_d   = '0;
          dat_low_d  = ~shreg_q[0];
          shreg_d    = {1'b0, shreg_q[9:1]};
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q == 4'd9) state_d = WAIT_ACK;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) state_d = ERROR;
        end
      end

      WAIT_ACK: begin
        if (fall) begin
          // Edge 11: device pulls data low to acknowledge
          to_cnt_d   = '0;
          edge_cnt_d = edge_cnt_q + 4'd1;
          state_d    = dat_sync ? ERROR : DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) state_d = ERROR;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      ERROR: begin
        error   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural keyboard model clocks the frame and
// captures line levels; expected outcomes go into a queue that a monitor
// pops whenever done or error pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       ps2_clk_in, ps2_dat_in;
  logic       clk_drive_low, dat_drive_low, busy, done, error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  // Open-drain bus: host drive-low wins over device level
  assign ps2_clk_in = clk_drive_low ? 1'b0 : dev_clk;
  assign ps2_dat_in = dat_drive_low ? 1'b0 : dev_dat;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .send          (send),
    .cmd_byte      (cmd_byte),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_dat_in    (ps2_dat_in),
    .clk_drive_low (clk_drive_low),
    .dat_drive_low (dat_drive_low),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        is_done;
    logic        chk_frame;
    logic [10:0] frame;   // bit0 start, bits 8:1 data, bit9 parity, bit10 stop
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          dev_edges = 11;
  bit          dev_ack = 1'b1;
  bit          dev_active = 1'b0;
  int          dev_edge_no = 0;
  logic [10:0] dev_frame = '0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Keyboard model: once the host releases the clock, sample the data line
  // before each falling edge, then drive ack low ahead of edge 11.
  initial begin
    forever begin
      @(negedge clk_drive_low);
      #1;
      if (busy && dev_edges > 0) begin
        dev_active  = 1'b1;
        dev_edge_no = 0;
        dev_frame   = '0;
        repeat (5) @(posedge clock);
        #1;
        for (int k = 0; k < dev_edges; k++) begin
          dev_frame[k] = ps2_dat_in;
          if (k == 10 && dev_ack) dev_dat = 1'b0;
          repeat (2) @(posedge clock);
          #1;
          dev_clk     = 1'b0;
          dev_edge_no = k + 1;
          repeat (8) @(posedge clock);
          #1;
          dev_clk = 1'b1;
          repeat (8) @(posedge clock);
          #1;
        end
        dev_dat    = 1'b1;
        dev_active = 1'b0;
      end
    end
  end

  // Monitor: every done/error pulse must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      tick();
      if (done || error) begin
        chk("mon_exclusive", {31'd0, done & error}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_pulse", {30'd0, done, error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind_done", {31'd0, done}, {31'd0, e.is_done});
          if (e.chk_frame) chk("mon_frame", {21'd0, dev_frame}, {21'd0, e.frame});
        end
      end
    end
  end

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_active && n < 1000) begin tick(); n++; end
    if (dev_active) chk("dev_idle_bound", 32'd1, 32'd0);
  endtask

  // One full transfer; optionally checks inhibit/start timing cycle by cycle
  task automatic run_xfer(input logic [7:0] cmd, input bit ack,
                          input logic [10:0] frame, input bit chk_timing);
    exp_t e;
    bit   ok;
    int   n;
    e.is_done = ack; e.chk_frame = 1'b1; e.frame = frame;
    exp_q.push_back(e);
    dev_edges = 11; dev_ack = ack;
    cmd_byte = cmd; send = 1'b1;
    tick();                      // now cycle T+1
    send = 1'b0; cmd_byte = ~cmd; // late changes must not matter
    if (chk_timing) begin
      ok = 1'b1;
      for (int i = 1; i <= INH; i++) begin
        if (!(clk_drive_low && !dat_drive_low && busy)) ok = 1'b0;
        if (i < INH) tick();
      end
      chk("inhibit_window", {31'd0, ok}, 32'd1);
      tick();
      chk("start_cycle", {30'd0, clk_drive_low, dat_drive_low}, 32'd3);
      tick();
      chk("tx_entry", {30'd0, clk_drive_low, dat_drive_low}, 32'd1);
    end
    n = 0;
    while (!(done || error) && n < 2000) begin tick(); n++; end
    if (!(done || error)) chk("result_bound", 32'd1, 32'd0);
    chk("lines_released", {30'd0, clk_drive_low, dat_drive_low}, 32'd0);
    chk("busy_in_pulse", {31'd0, busy}, 32'd1);
    tick();
    chk("busy_after", {31'd0, busy}, 32'd0);
    wait_dev_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   ok;
    int   n;

    repeat (3) tick();
    chk("reset_outputs", {27'd0, clk_drive_low, dat_drive_low, busy, done, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Set-LEDs with timing checks, then parity corner bytes
    run_xfer(PS2_CMD_SET_LEDS, 1'b1, 11'h7DA, 1'b1);
    run_xfer(8'h01,            1'b1, 11'h402, 1'b0);
    run_xfer(PS2_CMD_RESET,    1'b1, 11'h7FE, 1'b0);

    // Device leaves data high at edge 11: no acknowledge
    run_xfer(8'hAA, 1'b0, 11'h754, 1'b0);

    // Silent device: timeout 200 cycles after TX entry, mid-transfer send ignored
    e.is_done = 1'b0; e.chk_frame = 1'b0; e.frame = '0;
    exp_q.push_back(e);
    dev_edges = 0;
    cmd_byte = PS2_CMD_ENABLE; send = 1'b1;
    tick();
    send = 1'b0;
    repeat (21) tick();          // first TX cycle
    chk("tmo_tx_entry", {30'd0, clk_drive_low, dat_drive_low}, 32'd1);
    n = 0;
    while (!error && n < 400) begin
      tick(); n++;
      if (n == 30) begin send = 1'b1; cmd_byte = 8'h55; end
      else send = 1'b0;
    end
    send = 1'b0;
    chk("timeout_latency", n, TMO);
    chk("tmo_released", {30'd0, clk_drive_low, dat_drive_low}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) ok = 1'b0;
    end
    chk("send_while_busy_dropped", {31'd0, ok}, 32'd1);

    // Reset after edge 5: lines drop at once, no pulse; then a clean transfer
    dev_edges = 11; dev_ack = 1'b1; dev_edge_no = 0;
    cmd_byte = PS2_CMD_ENABLE; send = 1'b1;
    tick();
    send = 1'b0;
    n = 0;
    while (dev_edge_no < 5 && n < 2000) begin tick(); n++; end
    if (dev_edge_no < 5) chk("edge5_bound", 32'd1, 32'd0);
    reset = 1'b1;
    tick();
    chk("reset_mid_xfer", {27'd0, clk_drive_low, dat_drive_low, busy, done, error}, 32'd0);
    reset = 1'b0;
    wait_dev_idle();
    repeat (10) tick();
    run_xfer(PS2_CMD_ENABLE, 1'b1, 11'h5E8, 1'b0);

    repeat (10) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte, such as set-LEDs 0xED or reset 0xFF, from the FPGA to the keyboard over the same PS2_CLK/PS2_DAT pair that the keyboard receive path listens on. It drives both lines open-drain: it only ever pulls a line low or releases it, and the top level converts each drive-low enable into 0 or 1'bz. It is used for keyboard LED indication of rotor/plugboard mode and for keyboard re-initialisation after reset.

Parameters:
INHIBIT_CYCLES, 6000, clock cycles PS2_CLK is held low before the start bit (120 us at 50 MHz; must be ≥100 us).
TIMEOUT_CYCLES, 750000, maximum cycles between consecutive device falling edges before abort (15 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop depth of the synchronisers on ps2_clk_in and ps2_dat_in.

Ports:
clock  input  1  system clock (CLOCK_50 at the top level).
reset  input  1  synchronous, active-high reset.
send  input  1  request to transmit; sampled only in IDLE.
cmd_byte  input  8  byte to send; latched on the cycle send is accepted.
ps2_clk_in  input  1  raw PS2_CLK line level (asynchronous).
ps2_dat_in  input  1  raw PS2_DAT line level (asynchronous).
clk_drive_low  output  1  1 = pull PS2_CLK low, 0 = release.
dat_drive_low  output  1  1 = pull PS2_DAT low, 0 = release.
busy  output  1  high from the cycle after acceptance until returning to IDLE.
done  output  1  one-cycle pulse: device acknowledged.
error  output  1  one-cycle pulse: timeout, or no acknowledge.

Behaviour:
- Reset (synchronous, active-high): every output is 0, both lines are released, state is IDLE, all counters are 0. Reset asserted mid-transfer releases both lines on the next edge, with no done or error pulse.
- Both inputs pass through SYNC_STAGES flip-flops. fall = (previous synced clk == 1) && (current synced clk == 0).
- On acceptance: shift register = {1'b1 stop, odd parity = ~^cmd_byte, cmd_byte}, sent LSB first. Edge counter = 0.
- State IDLE: clk_drive_low=0, dat_drive_low=0, busy=0. If send=1 at cycle T, go to INHIBIT; busy=1 and clk_drive_low=1 from T+1.
- State INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go to START.
- State START (1 cycle): clk_drive_low=1 and dat_drive_low=1 (start bit 0). Then go to TX.
- State TX: clk_drive_low=0; dat_drive_low holds the start bit. On each fall, edges 1 to 10 present the next bit: dat_drive_low = ~bit. Edges 1–8 carry D0–D7, edge 9 parity, edge 10 stop (line released). After edge 10, go to WAIT_ACK.
- State WAIT_ACK: both lines released. On edge 11, sample synced data: 0 → DONE, 1 → ERROR.
- State DONE: done=1 for one cycle; busy remains 1 in that cycle. Then go to IDLE.
- State ERROR: error=1 for one cycle, both lines released. Then go to IDLE.
- Timeout: in TX and WAIT_ACK, a cycle counter clears on entry and on every fall. If it reaches TIMEOUT_CYCLES, go to ERROR. The counter width is clog2(TIMEOUT_CYCLES+1).
- send while busy=1 is ignored, not queued; cmd_byte changes after acceptance have no effect.
- A fall during IDLE, INHIBIT or START is ignored; only device-generated edges after START count.
- done and error are mutually exclusive and never asserted in the same cycle.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, START, TX, WAIT_ACK, DONE, ERROR};
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA;
  - default timing constants.
- Sub-module ps2_sync_edge: synchroniser plus falling-edge detector, outputs synced level and fall pulse. The keyboard receive path reuses it.

Test Plan (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, behavioural device model):
1. send with cmd_byte=8'hED; model clocks 11 edges and drives ack low on edge 11 → line after edges 1–10 reads 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy falls the next cycle.
2. send at cycle T → clk_drive_low high exactly cycles T+1..T+20; cycle T+21 has both drive-lows high; cycle T+22 has clk_drive_low=0.
3. cmd_byte=8'h01 → parity bit 0; cmd_byte=8'hFF → parity bit 1; both complete with done.
4. Model leaves data high at edge 11 → error pulse one cycle, done never asserted, lines released.
5. Model never clocks after START → error exactly 200 cycles after TX entry; second send during busy is ignored (only one transfer observed).
6. reset asserted after edge 5 → next cycle both drive-lows 0, busy 0, no done/error; a fresh send then completes normally.
